instr_decode: RTL and testbench
===============================

# instr_decode

ID stage of the five-stage MIPS pipeline. Consumes the IF/ID registers from the fetch stage. Provides:
- register-file read with write-back bypass;
- instruction decode;
- branch/jump resolution with MEM-stage forwarding;
- load-use and branch-operand hazard stalls;
- the redirect, stall and predictor/BTB update signals that fetch consumes;
- the ID/EX pipeline registers.

## Interface
Parameters: none (PHT index 8 bits, BTB index 6 bits, BTB tag 20 bits, fixed to match fetch).

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (asserted at 0)
- if_id_pc, if_id_pc_plus_4, if_id_instr  in  32 each  IF/ID registers
- if_pc  in  32  PC currently held in the fetch PC register
- id_ex_flush  in  1  synchronous bubble into ID/EX (from EX-stage control)
- ex_mem_reg_write, ex_mem_mem_read  in  1  MEM-stage control
- ex_mem_rd  in  5  MEM-stage destination
- ex_mem_alu_out  in  32  MEM-stage result
- wb_reg_write  in  1  write-back enable
- wb_rd  in  5  write-back destination
- wb_data  in  32  write-back value
- stall_if, stall_id  out  1  load enables for the PC and IF/ID; 1 = advance, 0 = hold
- pc_src  out  1  redirect, flushes IF/ID
- pc_branch  out  32  redirect target
- jump  out  1  jump decoded
- pc_jump  out  32  jump target
- pred_update_en  out  1  predictor update enable
- pred_update_index  out  8  predictor update index
- pred_update_taken  out  1  resolved branch direction
- btb_update_en  out  1  BTB update enable
- btb_update_index  out  6  BTB update index
- btb_update_tag  out  20  BTB update tag
- btb_update_target  out  32  BTB update target
- id_ex_reg_write, id_ex_mem_to_reg, id_ex_mem_read, id_ex_mem_write, id_ex_alu_src, id_ex_reg_dst  out  1  ID/EX control
- id_ex_alu_ctrl  out  3  ID/EX ALU operation
- id_ex_rs_data, id_ex_rt_data, id_ex_imm  out  32  ID/EX data
- id_ex_rs, id_ex_rt, id_ex_rd  out  5  ID/EX register numbers

## Operation
- **Bubble:** if_id_instr == 0 (the IF/ID flush value). No redirect, no updates, zero control to ID/EX.
- **Supported instructions:**
  - R-type (op 0) funct add 0x20 / sub 0x22 / and 0x24 / or 0x25 / slt 0x2A
  - lw 0x23, sw 0x2B, addi 0x08, beq 0x04, bne 0x05, j 0x02
  - Anything else decodes as a bubble.
- **alu_ctrl encoding:** add 010, sub 110, and 000, or 001, slt 111. lw/sw/addi use add.
- **id_ex_imm:** sign-extended instr[15:0].
- **Register file:** 32x32, written on rising clk when wb_reg_write and wb_rd != 0. Reads of $0 return 0. A same-cycle read of wb_rd returns wb_data (write-first bypass).
- **Branch operands:** if ex_mem_reg_write, ex_mem_rd != 0, ex_mem_rd matches the operand and ex_mem_mem_read == 0, the operand is ex_mem_alu_out; otherwise it is the register-file value.
- **Correct next PC (next_pc):**
  - beq/bne taken: if_id_pc_plus_4 + (imm << 2).
  - j: {if_id_pc_plus_4[31:28], instr[25:0], 2'b00}.
  - Otherwise: if_id_pc_plus_4.
- **stall** = load_use | branch_hazard.
  - load_use: id_ex_mem_read, id_ex_rt != 0, and id_ex_rt equals rs, or equals rt for R-type/beq/bne/sw.
  - branch_hazard: the ID instruction is beq/bne and either (id_ex_reg_write with the ID/EX destination equal to rs or rt, destination != 0), or (ex_mem_mem_read with ex_mem_rd equal to rs or rt, ex_mem_rd != 0).
  - ID/EX destination = id_ex_reg_dst ? id_ex_rd : id_ex_rt.
- **While stall:**
  - stall_if = stall_id = 0.
  - ID/EX loads a bubble.
  - pc_src, jump, pred_update_en and btb_update_en are all 0.
- **Redirect:** pc_src = valid & !stall & (next_pc != if_pc); pc_branch = next_pc. This also corrects wrong BTB predictions on any instruction.
- **Jump:** jump = valid j & !stall; pc_jump = the jump target. pc_src also fires, so IF/ID is flushed.
- **Predictor update** (valid beq/bne, !stall): pred_update_en = 1, index = if_id_pc[9:2], taken = outcome.
- **BTB update** (taken beq/bne or j, !stall): btb_update_en = 1, index = if_id_pc[11:6], tag = if_id_pc[31:12], target = next_pc.

## Timing
- The redirect, stall, jump and update outputs are combinational from IF/ID and the pipeline inputs in the same cycle.
- Each redirect and update is asserted for exactly one cycle per resolved instruction: in the first cycle the instruction is in ID with stall low.
- ID/EX registers update on rising clk.
  - Priority: reset > id_ex_flush > stall (load bubble) > decode.
  - Bubble = all control 0 and all data/register fields 0.
- **Reset (0):** all ID/EX outputs 0 and register file cleared, asynchronously. Combinational outputs follow from the zeroed inputs: bubble, hence pc_src = 0.
- Reset deasserting mid-stream: the first non-bubble instruction decodes normally; no state is carried.
- **Latency:** decode-to-EX 1 cycle. Branch penalty is 1 cycle (one fetched instruction flushed). Load-use costs 1 stall cycle. A branch dependent on a load costs 2 stall cycles.

## Test plan
- **Reset:** hold reset=0 with random inputs → all id_ex_* = 0. Release; feed instr 0 → pc_src = 0, stall_if = stall_id = 1.
- **Taken branch:** $1=$2=5, beq $1,$2,+3 at pc 0x40, if_pc=0x44 → pc_src = 1, pc_branch = 0x50, pred_update_en = 1 with index 0x10 and taken=1, btb_update_en = 1 with index 1, tag 0, target 0x50.
- **Not-taken bne:** bne with equal operands and if_pc = pc+4 → pc_src = 0, pred_update_taken = 0, btb_update_en = 0. Repeat with if_pc = 0x80 (stale BTB) → pc_src = 1, pc_branch = pc+4.
- **Load-use:** lw $3 in ID/EX, then add $4,$3,$3 in ID → one cycle of stall_if = stall_id = 0 with a bubble in ID/EX. The next cycle decodes add with reg_write = 1 and alu_ctrl 010.
- **Forwarding and branch hazard:**
  - beq $5,$0 with addi $5 in ID/EX → 1 stall cycle.
  - Next cycle, ex_mem_alu_out = 0 forwarded → branch taken.
  - With lw $5 instead → 2 stall cycles.
- **Write-back bypass and j:**
  - wb writes $7 = 0x1234 while ID reads $7 → id_ex_rs_data = 0x1234.
  - Write to $0 → $0 stays 0.
  - j 0x100 at pc 0x10 → jump = 1, pc_jump = 0x400, pc_src = 1, btb_update_en = 1.

Source files
------------

// File: rtl/instr_decode.sv
// ID stage of the five-stage MIPS pipeline: register file with write-back bypass,
// decode, branch/jump resolution, hazard stalls, fetch redirect/updates and ID/EX registers.
module instr_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_id_pc,
    input  logic [31:0] if_id_pc_plus_4,
    input  logic [31:0] if_id_instr,
    input  logic [31:0] if_pc,
    input  logic        id_ex_flush,
    input  logic        ex_mem_reg_write,
    input  logic        ex_mem_mem_read,
    input  logic [4:0]  ex_mem_rd,
    input  logic [31:0] ex_mem_alu_out,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        stall_if,
    output logic        stall_id,
    output logic        pc_src,
    output logic [31:0] pc_branch,
    output logic        jump,
    output logic [31:0] pc_jump,
    output logic        pred_update_en,
    output logic [7:0]  pred_update_index,
    output logic        pred_update_taken,
    output logic        btb_update_en,
    output logic [5:0]  btb_update_index,
    output logic [19:0] btb_update_tag,
    output logic [31:0] btb_update_target,
    output logic        id_ex_reg_write,
    output logic        id_ex_mem_to_reg,
    output logic        id_ex_mem_read,
    output logic        id_ex_mem_write,
    output logic        id_ex_alu_src,
    output logic        id_ex_reg_dst,
    output logic [2:0]  id_ex_alu_ctrl,
    output logic [31:0] id_ex_rs_data,
    output logic [31:0] id_ex_rt_data,
    output logic [31:0] id_ex_imm,
    output logic [4:0]  id_ex_rs,
    output logic [4:0]  id_ex_rt,
    output logic [4:0]  id_ex_rd
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    logic [5:0] op, funct;
    logic [4:0] rs, rt, rd;
    logic       is_r, is_lw, is_sw, is_addi, is_beq, is_bne, is_j, is_branch, valid;
    logic       uses_rs, uses_rt;
    logic       unused_bits;

    assign op    = if_id_instr[31:26];
    assign rs    = if_id_instr[25:21];
    assign rt    = if_id_instr[20:16];
    assign rd    = if_id_instr[15:11];
    assign funct = if_id_instr[5:0];
    assign unused_bits = ^{if_id_pc[1:0], if_id_instr[10:6]};

    // Unsupported encodings (including the all-zero flush value) fall out as bubbles.
    assign is_r      = (op == OP_RTYPE) && (funct == FN_ADD || funct == FN_SUB ||
                       funct == FN_AND || funct == FN_OR || funct == FN_SLT);
    assign is_lw     = (op == OP_LW);
    assign is_sw     = (op == OP_SW);
    assign is_addi   = (op == OP_ADDI);
    assign is_beq    = (op == OP_BEQ);
    assign is_bne    = (op == OP_BNE);
    assign is_j      = (op == OP_J);
    assign is_branch = is_beq | is_bne;
    assign valid     = is_r | is_lw | is_sw | is_addi | is_branch | is_j;
    assign uses_rs   = valid & ~is_j;
    assign uses_rt   = is_r | is_sw | is_branch;

    logic [31:0] regs [32];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_reg_write && wb_rd != 5'd0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Write-first read: a value being written back this cycle is seen immediately.
    logic [31:0] rs_val, rt_val;
    always_comb begin
        rs_val = regs[rs];
        rt_val = regs[rt];
        if (wb_reg_write && wb_rd == rs) rs_val = wb_data;
        if (wb_reg_write && wb_rd == rt) rt_val = wb_data;
        if (rs == 5'd0) rs_val = '0;
        if (rt == 5'd0) rt_val = '0;
    end

    logic        fwd_ok;
    logic [31:0] rs_opnd, rt_opnd;
    assign fwd_ok  = ex_mem_reg_write && !ex_mem_mem_read && ex_mem_rd != 5'd0;
    assign rs_opnd = (fwd_ok && ex_mem_rd == rs) ? ex_mem_alu_out : rs_val;
    assign rt_opnd = (fwd_ok && ex_mem_rd == rt) ? ex_mem_alu_out : rt_val;

    logic        branch_taken;
    logic [31:0] imm_ext, branch_target, jump_target, next_pc;
    assign branch_taken  = (is_beq && rs_opnd == rt_opnd) || (is_bne && rs_opnd != rt_opnd);
    assign imm_ext       = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
    assign branch_target = if_id_pc_plus_4 + (imm_ext << 2);
    assign jump_target   = {if_id_pc_plus_4[31:28], if_id_instr[25:0], 2'b00};
    assign next_pc       = is_j ? jump_target : (branch_taken ? branch_target : if_id_pc_plus_4);

    logic [4:0] id_ex_dest;
    logic       load_use, branch_hazard, stall;
    assign id_ex_dest    = id_ex_reg_dst ? id_ex_rd : id_ex_rt;
    assign load_use      = id_ex_mem_read && id_ex_rt != 5'd0 &&
                           ((uses_rs && id_ex_rt == rs) || (uses_rt && id_ex_rt == rt));
    assign branch_hazard = is_branch &&
                           ((id_ex_reg_write && id_ex_dest != 5'd0 && (id_ex_dest == rs || id_ex_dest == rt)) ||
                            (ex_mem_mem_read && ex_mem_rd != 5'd0 && (ex_mem_rd == rs || ex_mem_rd == rt)));
    assign stall         = load_use | branch_hazard;

    assign stall_if          = ~stall;
    assign stall_id          = ~stall;
    assign pc_src            = valid & ~stall & (next_pc != if_pc);
    assign pc_branch         = next_pc;
    assign jump              = is_j & ~stall;
    assign pc_jump           = jump_target;
    assign pred_update_en    = is_branch & ~stall;
    assign pred_update_index = if_id_pc[9:2];
    assign pred_update_taken = branch_taken;
    assign btb_update_en     = (branch_taken | is_j) & ~stall;
    assign btb_update_index  = if_id_pc[11:6];
    assign btb_update_tag    = if_id_pc[31:12];
    assign btb_update_target = next_pc;

    logic [2:0] dec_alu_ctrl;
    always_comb begin
        dec_alu_ctrl = 3'b000;
        if (is_lw || is_sw || is_addi) begin
            dec_alu_ctrl = 3'b010;
        end else if (is_r) begin
            case (funct)
                FN_ADD:  dec_alu_ctrl = 3'b010;
                FN_SUB:  dec_alu_ctrl = 3'b110;
                FN_AND:  dec_alu_ctrl = 3'b000;
                FN_OR:   dec_alu_ctrl = 3'b001;
                FN_SLT:  dec_alu_ctrl = 3'b111;
                default: dec_alu_ctrl = 3'b000;
            endcase
        end
    end

    // Flush, stall and undecodable instructions all load an all-zero bubble.
    logic load;
    assign load = valid & ~stall & ~id_ex_flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_ex_reg_write  <= 1'b0;
            id_ex_mem_to_reg <= 1'b0;
            id_ex_mem_read   <= 1'b0;
            id_ex_mem_write  <= 1'b0;
            id_ex_alu_src    <= 1'b0;
            id_ex_reg_dst    <= 1'b0;
            id_ex_alu_ctrl   <= 3'b000;
            id_ex_rs_data    <= '0;
            id_ex_rt_data    <= '0;
            id_ex_imm        <= '0;
            id_ex_rs         <= '0;
            id_ex_rt         <= '0;
            id_ex_rd         <= '0;
        end else begin
            id_ex_reg_write  <= load & (is_r | is_lw | is_addi);
            id_ex_mem_to_reg <= load & is_lw;
            id_ex_mem_read   <= load & is_lw;
            id_ex_mem_write  <= load & is_sw;
            id_ex_alu_src    <= load & (is_lw | is_sw | is_addi);
            id_ex_reg_dst    <= load & is_r;
            id_ex_alu_ctrl   <= load ? dec_alu_ctrl : 3'b000;
            id_ex_rs_data    <= load ? rs_val : '0;
            id_ex_rt_data    <= load ? rt_val : '0;
            id_ex_imm        <= load ? imm_ext : '0;
            id_ex_rs         <= load ? rs : '0;
            id_ex_rt         <= load ? rt : '0;
            id_ex_rd         <= load ? rd : '0;
        end
    end
endmodule

// File: tb/tb_instr_decode.sv
// Self-checking bench for instr_decode: directed pipeline scenarios followed by
// randomized traffic, all compared against an instruction-level reference model.
module tb_instr_decode;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_id_pc, if_id_pc_plus_4, if_id_instr, if_pc;
    logic        id_ex_flush, ex_mem_reg_write, ex_mem_mem_read;
    logic [4:0]  ex_mem_rd;
    logic [31:0] ex_mem_alu_out;
    logic        wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall_if, stall_id, pc_src, jump, pred_update_en, pred_update_taken, btb_update_en;
    logic [31:0] pc_branch, pc_jump, btb_update_target;
    logic [7:0]  pred_update_index;
    logic [5:0]  btb_update_index;
    logic [19:0] btb_update_tag;
    logic        id_ex_reg_write, id_ex_mem_to_reg, id_ex_mem_read, id_ex_mem_write;
    logic        id_ex_alu_src, id_ex_reg_dst;
    logic [2:0]  id_ex_alu_ctrl;
    logic [31:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm;
    logic [4:0]  id_ex_rs, id_ex_rt, id_ex_rd;

    instr_decode dut (
        .clk(clk), .reset(reset),
        .if_id_pc(if_id_pc), .if_id_pc_plus_4(if_id_pc_plus_4), .if_id_instr(if_id_instr), .if_pc(if_pc),
        .id_ex_flush(id_ex_flush),
        .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mem_read(ex_mem_mem_read),
        .ex_mem_rd(ex_mem_rd), .ex_mem_alu_out(ex_mem_alu_out),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_if(stall_if), .stall_id(stall_id), .pc_src(pc_src), .pc_branch(pc_branch),
        .jump(jump), .pc_jump(pc_jump),
        .pred_update_en(pred_update_en), .pred_update_index(pred_update_index),
        .pred_update_taken(pred_update_taken),
        .btb_update_en(btb_update_en), .btb_update_index(btb_update_index),
        .btb_update_tag(btb_update_tag), .btb_update_target(btb_update_target),
        .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_to_reg(id_ex_mem_to_reg),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_mem_write(id_ex_mem_write),
        .id_ex_alu_src(id_ex_alu_src), .id_ex_reg_dst(id_ex_reg_dst), .id_ex_alu_ctrl(id_ex_alu_ctrl),
        .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm),
        .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd)
    );

    always #5 clk = ~clk;

    typedef enum int {K_BUB, K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_LW, K_SW, K_ADDI, K_BEQ, K_BNE, K_J} kind_t;

    typedef struct packed {
        logic        reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst;
        logic [2:0]  alu_ctrl;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd;
    } idex_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    logic [31:0] m_rf [32];
    idex_t       m_idex, e_idex_next;
    logic        e_stall, e_pc_src, e_jump, e_pred_en, e_taken, e_btb_en;
    logic [31:0] e_next, e_jt;

    function automatic kind_t decode_kind(input logic [31:0] ins);
        kind_t k;
        k = K_BUB;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                       6'h20: k = K_ADD;
                       6'h22: k = K_SUB;
                       6'h24: k = K_AND;
                       6'h25: k = K_OR;
                       6'h2A: k = K_SLT;
                       default: k = K_BUB;
                   endcase
            6'h23: k = K_LW;
            6'h2B: k = K_SW;
            6'h08: k = K_ADDI;
            6'h04: k = K_BEQ;
            6'h05: k = K_BNE;
            6'h02: k = K_J;
            default: k = K_BUB;
        endcase
        return k;
    endfunction

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] s, t, d);
        return {6'h00, s, t, d, 5'h00, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] s, t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    function automatic logic [31:0] reg_read(input logic [4:0] n);
        if (n == 0) return 32'h0;
        if (wb_reg_write && wb_rd == n) return wb_data;
        return m_rf[n];
    endfunction

    function automatic logic [31:0] branch_operand(input logic [4:0] n);
        if (n != 0 && ex_mem_reg_write && !ex_mem_mem_read && ex_mem_rd == n) return ex_mem_alu_out;
        return reg_read(n);
    endfunction

    // Instruction-level reference: what the ID stage should do with the current inputs.
    task automatic model_comb();
        kind_t       k;
        logic [4:0]  s, t, dest;
        logic [31:0] offset;
        logic        reads_s, reads_t, is_br, lu, bh;
        k       = decode_kind(if_id_instr);
        s       = if_id_instr[25:21];
        t       = if_id_instr[20:16];
        reads_s = k inside {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_LW, K_SW, K_ADDI, K_BEQ, K_BNE};
        reads_t = k inside {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_SW, K_BEQ, K_BNE};
        is_br   = k inside {K_BEQ, K_BNE};
        lu = m_idex.mem_read && m_idex.rt != 0 &&
             ((reads_s && m_idex.rt == s) || (reads_t && m_idex.rt == t));
        dest = m_idex.reg_dst ? m_idex.rd : m_idex.rt;
        bh = is_br && ((m_idex.reg_write && dest != 0 && (dest == s || dest == t)) ||
                       (ex_mem_mem_read && ex_mem_rd != 0 && (ex_mem_rd == s || ex_mem_rd == t)));
        e_stall = lu || bh;
        e_taken = (k == K_BEQ && branch_operand(s) == branch_operand(t)) ||
                  (k == K_BNE && branch_operand(s) != branch_operand(t));
        offset  = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
        e_jt    = (if_id_pc_plus_4 & 32'hF000_0000) + ((if_id_instr & 32'h03FF_FFFF) * 4);
        if (k == K_J)     e_next = e_jt;
        else if (e_taken) e_next = if_id_pc_plus_4 + offset * 4;
        else              e_next = if_id_pc_plus_4;
        e_pc_src  = (k != K_BUB) && !e_stall && (e_next != if_pc);
        e_jump    = (k == K_J) && !e_stall;
        e_pred_en = is_br && !e_stall;
        e_btb_en  = (e_taken || k == K_J) && !e_stall;

        e_idex_next = '0;
        if (!id_ex_flush && !e_stall && k != K_BUB) begin
            e_idex_next.reg_write  = k inside {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_LW, K_ADDI};
            e_idex_next.mem_to_reg = (k == K_LW);
            e_idex_next.mem_read   = (k == K_LW);
            e_idex_next.mem_write  = (k == K_SW);
            e_idex_next.alu_src    = k inside {K_LW, K_SW, K_ADDI};
            e_idex_next.reg_dst    = k inside {K_ADD, K_SUB, K_AND, K_OR, K_SLT};
            case (k)
                K_ADD, K_LW, K_SW, K_ADDI: e_idex_next.alu_ctrl = 3'b010;
                K_SUB:                     e_idex_next.alu_ctrl = 3'b110;
                K_OR:                      e_idex_next.alu_ctrl = 3'b001;
                K_SLT:                     e_idex_next.alu_ctrl = 3'b111;
                default:                   e_idex_next.alu_ctrl = 3'b000;
            endcase
            e_idex_next.rs_data = reg_read(s);
            e_idex_next.rt_data = reg_read(t);
            e_idex_next.imm     = offset;
            e_idex_next.rs      = s;
            e_idex_next.rt      = t;
            e_idex_next.rd      = if_id_instr[15:11];
        end
    endtask

    task automatic model_clock();
        if (!reset) begin
            m_idex = '0;
            foreach (m_rf[i]) m_rf[i] = '0;
        end else begin
            if (wb_reg_write && wb_rd != 0) m_rf[wb_rd] = wb_data;
            m_idex = e_idex_next;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idex();
        check_output("id_ex_reg_write",  32'(id_ex_reg_write),  32'(m_idex.reg_write));
        check_output("id_ex_mem_to_reg", 32'(id_ex_mem_to_reg), 32'(m_idex.mem_to_reg));
        check_output("id_ex_mem_read",   32'(id_ex_mem_read),   32'(m_idex.mem_read));
        check_output("id_ex_mem_write",  32'(id_ex_mem_write),  32'(m_idex.mem_write));
        check_output("id_ex_alu_src",    32'(id_ex_alu_src),    32'(m_idex.alu_src));
        check_output("id_ex_reg_dst",    32'(id_ex_reg_dst),    32'(m_idex.reg_dst));
        check_output("id_ex_alu_ctrl",   32'(id_ex_alu_ctrl),   32'(m_idex.alu_ctrl));
        check_output("id_ex_rs_data",    id_ex_rs_data,         m_idex.rs_data);
        check_output("id_ex_rt_data",    id_ex_rt_data,         m_idex.rt_data);
        check_output("id_ex_imm",        id_ex_imm,             m_idex.imm);
        check_output("id_ex_rs",         32'(id_ex_rs),         32'(m_idex.rs));
        check_output("id_ex_rt",         32'(id_ex_rt),         32'(m_idex.rt));
        check_output("id_ex_rd",         32'(id_ex_rd),         32'(m_idex.rd));
    endtask

    // Inputs are already driven; settle, then compare the combinational outputs.
    task automatic apply_stimulus();
        #1;
        model_comb();
        check_output("stall_if",          32'(stall_if),          32'(!e_stall));
        check_output("stall_id",          32'(stall_id),          32'(!e_stall));
        check_output("pc_src",            32'(pc_src),            32'(e_pc_src));
        check_output("pc_branch",         pc_branch,              e_next);
        check_output("jump",              32'(jump),              32'(e_jump));
        check_output("pc_jump",           pc_jump,                e_jt);
        check_output("pred_update_en",    32'(pred_update_en),    32'(e_pred_en));
        check_output("pred_update_index", 32'(pred_update_index), (if_id_pc / 4) % 256);
        check_output("pred_update_taken", 32'(pred_update_taken), 32'(e_taken));
        check_output("btb_update_en",     32'(btb_update_en),     32'(e_btb_en));
        check_output("btb_update_index",  32'(btb_update_index),  (if_id_pc / 64) % 64);
        check_output("btb_update_tag",    32'(btb_update_tag),    if_id_pc / 4096);
        check_output("btb_update_target", btb_update_target,      e_next);
    endtask

    task automatic clock_cycle();
        @(posedge clk);
        model_clock();
        #1;
        check_idex();
    endtask

    task automatic idle_inputs();
        if_id_pc = '0; if_id_pc_plus_4 = '0; if_id_instr = '0; if_pc = '0;
        id_ex_flush = 1'b0; ex_mem_reg_write = 1'b0; ex_mem_mem_read = 1'b0;
        ex_mem_rd = '0; ex_mem_alu_out = '0;
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
    endtask

    task automatic set_fetch(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] fetch_pc);
        if_id_pc = pc; if_id_pc_plus_4 = pc + 4; if_id_instr = ins; if_pc = fetch_pc;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  s, t, d;
        logic [15:0] imm;
        s   = 5'($urandom_range(0, 3));
        t   = 5'($urandom_range(0, 3));
        d   = 5'($urandom_range(0, 3));
        imm = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 8)) : 16'($urandom);
        case ($urandom_range(0, 12))
            0:  return r_ins(6'h20, s, t, d);
            1:  return r_ins(6'h22, s, t, d);
            2:  return r_ins(6'h24, s, t, d);
            3:  return r_ins(6'h25, s, t, d);
            4:  return r_ins(6'h2A, s, t, d);
            5:  return i_ins(6'h23, s, t, imm);
            6:  return i_ins(6'h2B, s, t, imm);
            7:  return i_ins(6'h08, s, t, imm);
            8:  return i_ins(6'h04, s, t, imm);
            9:  return i_ins(6'h05, s, t, imm);
            10: return {6'h02, 26'($urandom)};
            11: return 32'h0;
            default: return $urandom;
        endcase
    endfunction

    task automatic random_inputs();
        logic [31:0] pc;
        pc = $urandom & 32'hFFFF_FFFC;
        set_fetch(pc, rand_instr(), ($urandom_range(0, 1) == 1) ? pc + 4 : ($urandom & 32'hFFFF_FFFC));
        id_ex_flush      = ($urandom_range(0, 7) == 0);
        ex_mem_reg_write = 1'($urandom_range(0, 1));
        ex_mem_mem_read  = ($urandom_range(0, 3) == 0);
        ex_mem_rd        = 5'($urandom_range(0, 3));
        ex_mem_alu_out   = 32'($urandom_range(0, 3));
        wb_reg_write     = 1'($urandom_range(0, 1));
        wb_rd            = 5'($urandom_range(0, 3));
        wb_data          = 32'($urandom_range(0, 3));
    endtask

    initial begin
        reset = 1'b0;
        m_idex = '0;
        e_idex_next = '0;
        foreach (m_rf[i]) m_rf[i] = '0;
        $display("[TB] reset with random inputs");
        repeat (3) begin
            random_inputs();
            @(posedge clk);
            model_clock();
            #1;
            check_idex();
        end

        idle_inputs();
        reset = 1'b1;
        apply_stimulus();
        check_output("rel_pc_src", 32'(pc_src), 32'h0);
        check_output("rel_stall_if", 32'(stall_if), 32'h1);
        check_output("rel_stall_id", 32'(stall_id), 32'h1);
        clock_cycle();

        // Preload $1 = $2 = 5 and $5 = 9 through the write-back port.
        wb_reg_write = 1'b1; wb_data = 32'd5; wb_rd = 5'd1;
        apply_stimulus(); clock_cycle();
        wb_rd = 5'd2;
        apply_stimulus(); clock_cycle();
        wb_rd = 5'd5; wb_data = 32'd9;
        apply_stimulus(); clock_cycle();
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;

        $display("[TB] taken beq");
        set_fetch(32'h40, i_ins(6'h04, 5'd1, 5'd2, 16'd3), 32'h44);
        apply_stimulus();
        check_output("beq_pc_src", 32'(pc_src), 32'h1);
        check_output("beq_pc_branch", pc_branch, 32'h50);
        check_output("beq_pred_en", 32'(pred_update_en), 32'h1);
        check_output("beq_pred_index", 32'(pred_update_index), 32'h10);
        check_output("beq_pred_taken", 32'(pred_update_taken), 32'h1);
        check_output("beq_btb_en", 32'(btb_update_en), 32'h1);
        check_output("beq_btb_index", 32'(btb_update_index), 32'h1);
        check_output("beq_btb_tag", 32'(btb_update_tag), 32'h0);
        check_output("beq_btb_target", btb_update_target, 32'h50);
        clock_cycle();

        $display("[TB] not-taken bne");
        set_fetch(32'h60, i_ins(6'h05, 5'd1, 5'd2, 16'h0010), 32'h64);
        apply_stimulus();
        check_output("bne_pc_src", 32'(pc_src), 32'h0);
        check_output("bne_pred_en", 32'(pred_update_en), 32'h1);
        check_output("bne_pred_taken", 32'(pred_update_taken), 32'h0);
        check_output("bne_btb_en", 32'(btb_update_en), 32'h0);
        clock_cycle();
        if_pc = 32'h80;
        apply_stimulus();
        check_output("bne_stale_pc_src", 32'(pc_src), 32'h1);
        check_output("bne_stale_pc_branch", pc_branch, 32'h64);
        clock_cycle();

        $display("[TB] load-use");
        set_fetch(32'h70, i_ins(6'h23, 5'd0, 5'd3, 16'd4), 32'h74);
        apply_stimulus(); clock_cycle();
        check_output("lw_id_ex_mem_read", 32'(id_ex_mem_read), 32'h1);
        set_fetch(32'h74, r_ins(6'h20, 5'd3, 5'd3, 5'd4), 32'h78);
        apply_stimulus();
        check_output("lu_stall_if", 32'(stall_if), 32'h0);
        check_output("lu_stall_id", 32'(stall_id), 32'h0);
        clock_cycle();
        check_output("lu_bubble_reg_write", 32'(id_ex_reg_write), 32'h0);
        apply_stimulus();
        check_output("lu_resume_stall_if", 32'(stall_if), 32'h1);
        clock_cycle();
        check_output("lu_add_reg_write", 32'(id_ex_reg_write), 32'h1);
        check_output("lu_add_alu_ctrl", 32'(id_ex_alu_ctrl), 32'h2);

        $display("[TB] branch hazard with forwarding");
        set_fetch(32'h80, i_ins(6'h08, 5'd0, 5'd5, 16'd7), 32'h84);
        apply_stimulus(); clock_cycle();
        set_fetch(32'h100, i_ins(6'h04, 5'd5, 5'd0, 16'd2), 32'h104);
        apply_stimulus();
        check_output("bh_stall_if", 32'(stall_if), 32'h0);
        check_output("bh_pc_src", 32'(pc_src), 32'h0);
        clock_cycle();
        ex_mem_reg_write = 1'b1; ex_mem_rd = 5'd5; ex_mem_alu_out = 32'h0;
        apply_stimulus();
        check_output("fwd_stall_if", 32'(stall_if), 32'h1);
        check_output("fwd_pc_src", 32'(pc_src), 32'h1);
        check_output("fwd_pc_branch", pc_branch, 32'h10C);
        check_output("fwd_taken", 32'(pred_update_taken), 32'h1);
        clock_cycle();
        ex_mem_reg_write = 1'b0; ex_mem_rd = '0;

        $display("[TB] branch after load");
        set_fetch(32'h110, i_ins(6'h23, 5'd0, 5'd5, 16'd0), 32'h114);
        apply_stimulus(); clock_cycle();
        set_fetch(32'h200, i_ins(6'h04, 5'd5, 5'd0, 16'd2), 32'h204);
        apply_stimulus();
        check_output("lb_stall1", 32'(stall_if), 32'h0);
        clock_cycle();
        ex_mem_reg_write = 1'b1; ex_mem_mem_read = 1'b1; ex_mem_rd = 5'd5; ex_mem_alu_out = 32'h200;
        apply_stimulus();
        check_output("lb_stall2", 32'(stall_if), 32'h0);
        clock_cycle();
        ex_mem_reg_write = 1'b0; ex_mem_mem_read = 1'b0; ex_mem_rd = '0; ex_mem_alu_out = '0;
        wb_reg_write = 1'b1; wb_rd = 5'd5; wb_data = 32'h0;
        apply_stimulus();
        check_output("lb_resolve_stall_if", 32'(stall_if), 32'h1);
        check_output("lb_resolve_pc_branch", pc_branch, 32'h20C);
        clock_cycle();

        $display("[TB] write-back bypass and $0");
        set_fetch(32'h300, r_ins(6'h20, 5'd7, 5'd0, 5'd8), 32'h304);
        wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 32'h1234;
        apply_stimulus(); clock_cycle();
        check_output("bypass_rs_data", id_ex_rs_data, 32'h1234);
        set_fetch(32'h304, r_ins(6'h20, 5'd0, 5'd0, 5'd9), 32'h308);
        wb_rd = 5'd0; wb_data = 32'hDEAD_BEEF;
        apply_stimulus(); clock_cycle();
        check_output("r0_same_cycle", id_ex_rs_data, 32'h0);
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
        apply_stimulus(); clock_cycle();
        check_output("r0_stays_zero", id_ex_rt_data, 32'h0);

        $display("[TB] jump");
        set_fetch(32'h10, {6'h02, 26'h100}, 32'h14);
        apply_stimulus();
        check_output("j_jump", 32'(jump), 32'h1);
        check_output("j_pc_jump", pc_jump, 32'h400);
        check_output("j_pc_src", 32'(pc_src), 32'h1);
        check_output("j_btb_en", 32'(btb_update_en), 32'h1);
        clock_cycle();

        set_fetch(32'h20, i_ins(6'h08, 5'd0, 5'd6, 16'd1), 32'h24);
        id_ex_flush = 1'b1;
        apply_stimulus(); clock_cycle();
        check_output("flush_reg_write", 32'(id_ex_reg_write), 32'h0);
        id_ex_flush = 1'b0;

        $display("[TB] random traffic");
        repeat (400) begin
            random_inputs();
            apply_stimulus();
            clock_cycle();
        end

        reset = 1'b0;
        #1;
        m_idex = '0;
        foreach (m_rf[i]) m_rf[i] = '0;
        check_idex();
        repeat (2) begin
            random_inputs();
            apply_stimulus();
            clock_cycle();
        end
        reset = 1'b1;
        repeat (200) begin
            random_inputs();
            apply_stimulus();
            clock_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
